// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one Avalon-MM burst port between two masters
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int BURST_W  = 11,
  parameter int BE_W     = 16,
  parameter int RD_OUTST = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [2*ADDR_W-1:0]  m_address_i,
  input  logic [1:0]           m_read_i,
  input  logic [1:0]           m_write_i,
  input  logic [2*DATA_W-1:0]  m_writedata_i,
  input  logic [2*BURST_W-1:0] m_burstcount_i,
  input  logic [2*BE_W-1:0]    m_byteenable_i,
  output logic [1:0]           m_waitrequest_o,
  output logic [DATA_W-1:0]    m_readdata_o,
  output logic [1:0]           m_readdatavalid_o,
  output logic [ADDR_W-1:0]    mem_address_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [DATA_W-1:0]    mem_writedata_o,
  output logic [BURST_W-1:0]   mem_burstcount_o,
  output logic [BE_W-1:0]      mem_byteenable_o,
  input  logic                 mem_waitrequest_i,
  input  logic [DATA_W-1:0]    mem_readdata_i,
  input  logic                 mem_readdatavalid_i,
  output logic                 rd_unexpected_o
);
  localparam int PW = $clog2(RD_OUTST);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RD_OUTST);
  typedef enum logic {IDLE, WR_BURST} state_t;
  state_t               r_state;
  logic                 r_ptr;
  logic                 r_lock;
  logic [BURST_W-1:0]   r_wr_cnt;
  logic [BURST_W-1:0]   r_rd_cnt;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_wp;
  logic [PW-1:0]        r_rp;
  logic                 r_fid [RD_OUTST];
  logic [BURST_W-1:0]   r_fbc [RD_OUTST];
  logic                 r_unexp;
  logic                 w_full;
  logic                 w_empty;
  logic [1:0]           w_elig;
  logic                 w_win;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_acc;
  logic                 w_push;
  logic                 w_pop;
  logic [BURST_W-1:0]   w_raw_bc;
  logic [BURST_W-1:0]   w_bc;
  logic                 w_hid;
  logic [BURST_W-1:0]   w_hbc;
  // Arbitration, command mux and zero-latency read-response routing
  always_comb begin
    w_full            = r_cnt == FULL_CNT;
    w_empty           = r_cnt == '0;
    w_elig            = m_write_i | (m_read_i & {2{!w_full}});
    w_win             = (r_state == WR_BURST) ? r_lock : (&w_elig ? r_ptr : w_elig[1]);
    w_wr              = rst_n_i & m_write_i[w_win];
    w_rd              = rst_n_i & (r_state == IDLE) & m_read_i[w_win] & !m_write_i[w_win] & !w_full;
    w_acc             = (w_rd | w_wr) & !mem_waitrequest_i;
    w_raw_bc          = w_win ? m_burstcount_i[2*BURST_W-1:BURST_W] : m_burstcount_i[BURST_W-1:0];
    w_bc              = (w_raw_bc == '0) ? BURST_W'(1) : w_raw_bc;
    w_hid             = r_fid[r_rp];
    w_hbc             = r_fbc[r_rp];
    w_push            = w_acc & w_rd;
    w_pop             = mem_readdatavalid_i & !w_empty & (r_rd_cnt == w_hbc - 1'b1);
    mem_address_o     = w_win ? m_address_i[2*ADDR_W-1:ADDR_W] : m_address_i[ADDR_W-1:0];
    mem_writedata_o   = w_win ? m_writedata_i[2*DATA_W-1:DATA_W] : m_writedata_i[DATA_W-1:0];
    mem_byteenable_o  = w_win ? m_byteenable_i[2*BE_W-1:BE_W] : m_byteenable_i[BE_W-1:0];
    mem_burstcount_o  = w_raw_bc;
    mem_read_o        = w_rd;
    mem_write_o       = w_wr;
    m_waitrequest_o   = ~({w_win, !w_win} & {2{w_rd | w_wr}}) | {2{mem_waitrequest_i}};
    m_readdata_o      = mem_readdata_i;
    m_readdatavalid_o = {2{mem_readdatavalid_i & !w_empty}} & {w_hid, !w_hid};
    rd_unexpected_o   = r_unexp;
  end
  // Response FIFO payload; validity is tracked by the reset pointers/count
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fid[r_wp] <= w_win;
      r_fbc[r_wp] <= w_bc;
    end
  end
  // Burst-lock FSM, round-robin pointer, FIFO pointers and response beat counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_lock   <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_unexp  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (mem_readdatavalid_i & w_empty) r_unexp <= 1'b1;
      if (mem_readdatavalid_i & !w_empty) r_rd_cnt <= w_pop ? '0 : r_rd_cnt + 1'b1;
      if (w_acc) begin
        if (r_state == IDLE) begin
          if (w_wr && w_bc != BURST_W'(1)) begin
            r_state  <= WR_BURST;
            r_lock   <= w_win;
            r_wr_cnt <= w_bc - 1'b1;
          end else begin
            r_ptr <= !w_win;
          end
        end else begin
          r_wr_cnt <= r_wr_cnt - 1'b1;
          if (r_wr_cnt == BURST_W'(1)) begin
            r_state <= IDLE;
            r_ptr   <= !r_lock;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized reads against a queue model
module tb_mem_port_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  m_address;
  logic [1:0]   m_read;
  logic [1:0]   m_write;
  logic [255:0] m_wdata;
  logic [21:0]  m_bc;
  logic [31:0]  m_be;
  logic [1:0]   m_wait;
  logic [127:0] m_rdata;
  logic [1:0]   m_rdv;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_wdata;
  logic [10:0]  mem_bc;
  logic [15:0]  mem_be;
  logic         mem_wait;
  logic [127:0] mem_rdata;
  logic         mem_rdv;
  logic         unexp;
  int total = 0;
  int bad = 0;
  int q_id[$];
  int q_bc[$];

  mem_port_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_address_i(m_address), .m_read_i(m_read), .m_write_i(m_write),
    .m_writedata_i(m_wdata), .m_burstcount_i(m_bc), .m_byteenable_i(m_be),
    .m_waitrequest_o(m_wait), .m_readdata_o(m_rdata), .m_readdatavalid_o(m_rdv),
    .mem_address_o(mem_address), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_writedata_o(mem_wdata), .mem_burstcount_o(mem_bc), .mem_byteenable_o(mem_be),
    .mem_waitrequest_i(mem_wait), .mem_readdata_i(mem_rdata),
    .mem_readdatavalid_i(mem_rdv), .rd_unexpected_o(unexp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic pend [2];
    int   p_bc [2];
    logic [31:0] p_addr [2];
    int   ptr;
    int   head_done;
    int   win;
    logic full;
    logic issue;
    rst_n = 1'b0; m_address = '0; m_read = '0; m_write = '0; m_wdata = '0;
    m_bc = '0; m_be = '1; mem_wait = 1'b0; mem_rdata = '0; mem_rdv = 1'b0;
    #12;
    chk("rst_wait", m_wait, 2'b11);
    chk("rst_rdv", m_rdv, 2'b00);
    chk("rst_mem_rd", mem_read, 1'b0);
    chk("rst_mem_wr", mem_write, 1'b0);
    chk("rst_unexp", unexp, 1'b0);
    tick();
    // two simultaneous single reads, pointer at 0
    rst_n = 1'b1;
    m_address = {32'h20, 32'h10}; m_bc = {11'd1, 11'd1}; m_read = 2'b11;
    #1;
    chk("t1_rd0", mem_read, 1'b1);
    chk("t1_addr0", mem_address, 32'h10);
    chk("t1_wait0", m_wait, 2'b10);
    tick();
    m_read = 2'b10;
    #1;
    chk("t1_rd1", mem_read, 1'b1);
    chk("t1_addr1", mem_address, 32'h20);
    chk("t1_wait1", m_wait, 2'b01);
    tick();
    m_read = 2'b00;
    mem_rdv = 1'b1; mem_rdata = 128'hA;
    #1;
    chk("t1_rdv_a", m_rdv, 2'b01);
    chk("t1_data_a", m_rdata, 128'hA);
    tick();
    mem_rdata = 128'hB;
    #1;
    chk("t1_rdv_b", m_rdv, 2'b10);
    chk("t1_data_b", m_rdata, 128'hB);
    tick();
    mem_rdv = 1'b0;
    // m0 write burst of 4 while m1 read waits
    m_write = 2'b01; m_bc = {11'd1, 11'd4}; m_read = 2'b10; m_address = {32'h30, 32'h100};
    for (int i = 0; i < 4; i++) begin
      m_wdata[127:0] = 128'(100 + i);
      #1;
      chk("t2_wr", mem_write, 1'b1);
      chk("t2_rd_blk", mem_read, 1'b0);
      chk("t2_wdata", mem_wdata, 128'(100 + i));
      chk("t2_wait", m_wait, 2'b10);
      tick();
    end
    m_write = 2'b00;
    #1;
    chk("t2_m1_rd", mem_read, 1'b1);
    chk("t2_m1_addr", mem_address, 32'h30);
    chk("t2_m1_wait", m_wait, 2'b01);
    tick();
    m_read = 2'b00; mem_rdv = 1'b1; mem_rdata = 128'hC;
    #1;
    chk("t2_rdv", m_rdv, 2'b10);
    tick();
    mem_rdv = 1'b0;
    // m0 burst of 3 with a 2-cycle gap after the first beat
    m_write = 2'b01; m_bc = {11'd1, 11'd3}; m_read = 2'b10; m_address = {32'h40, 32'h200};
    #1;
    chk("t3_beat1_wait", m_wait, 2'b10);
    tick();
    m_write = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_gap_wait", m_wait, 2'b11);
      chk("t3_gap_rd", mem_read, 1'b0);
      tick();
    end
    m_write = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_beat_wait", m_wait, 2'b10);
      chk("t3_beat_wr", mem_write, 1'b1);
      tick();
    end
    m_write = 2'b00;
    #1;
    chk("t3_m1_rd", mem_read, 1'b1);
    chk("t3_m1_wait", m_wait, 2'b01);
    tick();
    m_read = 2'b00; mem_rdv = 1'b1;
    #1;
    chk("t3_rdv", m_rdv, 2'b10);
    tick();
    mem_rdv = 1'b0;
    // fill the response FIFO from m1, then check blocking and write bypass
    m_read = 2'b10; m_bc = {11'd1, 11'd1};
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_fill_wait", m_wait, 2'b01);
      tick();
    end
    #1;
    chk("t4_full_wait", m_wait, 2'b11);
    chk("t4_full_rd", mem_read, 1'b0);
    m_write = 2'b01;
    #1;
    chk("t4_wr_ok", mem_write, 1'b1);
    chk("t4_wr_wait", m_wait, 2'b10);
    tick();
    m_write = 2'b00; m_read = 2'b00; mem_rdv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_drain_rdv", m_rdv, 2'b10);
      tick();
    end
    mem_rdv = 1'b0;
    // m0 read burst 3, then m1 read burst 2
    m_read = 2'b01; m_bc = {11'd2, 11'd3}; m_address = {32'h60, 32'h50};
    #1;
    chk("t5_bc0", mem_bc, 11'd3);
    chk("t5_wait0", m_wait, 2'b10);
    tick();
    m_read = 2'b10;
    #1;
    chk("t5_bc1", mem_bc, 11'd2);
    chk("t5_wait1", m_wait, 2'b01);
    tick();
    m_read = 2'b00; mem_rdv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mem_rdata = 128'(k + 1);
      #1;
      chk("t5_route", m_rdv, (k < 3) ? 2'b01 : 2'b10);
      chk("t5_data", m_rdata, 128'(k + 1));
      tick();
    end
    #1;
    chk("t6_stray_rdv", m_rdv, 2'b00);
    tick();
    mem_rdv = 1'b0;
    #1;
    chk("t6_unexp", unexp, 1'b1);
    tick();
    chk("t6_unexp_sticky", unexp, 1'b1);
    // reset in the middle of an m1 write burst, pointer at 1 beforehand
    m_write = 2'b01; m_bc = {11'd4, 11'd1};
    #1;
    chk("t7_pre_wait", m_wait, 2'b10);
    tick();
    m_write = 2'b10;
    tick();
    tick();
    #1;
    chk("t7_lock_wait", m_wait, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_wait", m_wait, 2'b11);
    chk("t7_rst_wr", mem_write, 1'b0);
    chk("t7_rst_unexp", unexp, 1'b0);
    #2;
    rst_n = 1'b1; m_write = 2'b00; m_read = 2'b11; m_bc = {11'd1, 11'd1};
    m_address = {32'h70, 32'h80};
    #1;
    chk("t7_post_rd", mem_read, 1'b1);
    chk("t7_post_wait", m_wait, 2'b10);
    chk("t7_post_addr", mem_address, 32'h80);
    m_read = 2'b00;
    tick();
    // randomized reads with random memory stalls and responses
    ptr = 0; head_done = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    p_bc[0] = 0; p_bc[1] = 0; p_addr[0] = '0; p_addr[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p_bc[i] = $urandom_range(0, 3);
          p_addr[i] = $urandom;
        end
      end
      m_read = {pend[1], pend[0]};
      m_address = {p_addr[1], p_addr[0]};
      m_bc = {11'(p_bc[1]), 11'(p_bc[0])};
      mem_wait = ($urandom_range(0, 3) == 0);
      mem_rdv = (q_id.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      full = (q_id.size() == 8);
      issue = !full && (pend[0] || pend[1]);
      win = (pend[0] && pend[1]) ? ptr : (pend[1] ? 1 : 0);
      if (issue) begin
        chk("rnd_rd", mem_read, 1'b1);
        chk("rnd_addr", mem_address, p_addr[win]);
        chk("rnd_bc", mem_bc, 11'(p_bc[win]));
        chk("rnd_wait", m_wait, mem_wait ? 2'b11 : (win == 1 ? 2'b01 : 2'b10));
      end else begin
        chk("rnd_idle_rd", mem_read, 1'b0);
        chk("rnd_idle_wait", m_wait, 2'b11);
      end
      if (mem_rdv) begin
        chk("rnd_rdv", m_rdv, (q_id[0] == 1) ? 2'b10 : 2'b01);
        chk("rnd_rdata", m_rdata, mem_rdata);
        head_done++;
        if (head_done == ((q_bc[0] == 0) ? 1 : q_bc[0])) begin
          void'(q_id.pop_front());
          void'(q_bc.pop_front());
          head_done = 0;
        end
      end else begin
        chk("rnd_no_rdv", m_rdv, 2'b00);
      end
      if (issue && !mem_wait) begin
        q_id.push_back(win);
        q_bc.push_back(p_bc[win]);
        pend[win] = 1'b0;
        ptr = 1 - win;
      end
      tick();
    end
    m_read = 2'b00; mem_wait = 1'b0;
    for (int c = 0; c < 64 && q_id.size() > 0; c++) begin
      mem_rdv = 1'b1;
      #1;
      chk("drain_rdv", m_rdv, (q_id[0] == 1) ? 2'b10 : 2'b01);
      head_done++;
      if (head_done == ((q_bc[0] == 0) ? 1 : q_bc[0])) begin
        void'(q_id.pop_front());
        void'(q_bc.pop_front());
        head_done = 0;
      end
      tick();
    end
    mem_rdv = 1'b0;
    total++;
    assert (q_id.size() == 0) else begin
      bad++;
      $error("FAIL drain_bound: got %0d pending want 0", q_id.size());
    end
    #1;
    chk("rnd_unexp", unexp, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
